// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: the tap_controller 4-bit state encoding, the
// driver command op codes, the driver's internal phases, and the
// IEEE 1149.1 TAP next-state function.
package jtag_pkg;

    localparam logic [3:0] TAP_TLR    = 4'h0;
    localparam logic [3:0] TAP_RTI    = 4'h1;
    localparam logic [3:0] TAP_SEL_DR = 4'h2;
    localparam logic [3:0] TAP_CAP_DR = 4'h3;
    localparam logic [3:0] TAP_SH_DR  = 4'h4;
    localparam logic [3:0] TAP_EX1_DR = 4'h5;
    localparam logic [3:0] TAP_PAU_DR = 4'h6;
    localparam logic [3:0] TAP_EX2_DR = 4'h7;
    localparam logic [3:0] TAP_UPD_DR = 4'h8;
    localparam logic [3:0] TAP_SEL_IR = 4'h9;
    localparam logic [3:0] TAP_CAP_IR = 4'hA;
    localparam logic [3:0] TAP_SH_IR  = 4'hB;
    localparam logic [3:0] TAP_EX1_IR = 4'hC;
    localparam logic [3:0] TAP_PAU_IR = 4'hD;
    localparam logic [3:0] TAP_EX2_IR = 4'hE;
    localparam logic [3:0] TAP_UPD_IR = 4'hF;

    localparam logic [1:0] OP_RESET    = 2'd0;
    localparam logic [1:0] OP_IDLE     = 2'd1;
    localparam logic [1:0] OP_SHIFT_IR = 2'd2;
    localparam logic [1:0] OP_SHIFT_DR = 2'd3;

    typedef enum logic [2:0] {
        D_READY,
        D_PREFIX,
        D_WALK,
        D_SHIFT,
        D_DONE
    } drv_state_e;

    // TAP state transition for one TCK edge with the given TMS level.
    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
        case (s)
            TAP_TLR:    return tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    return tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: return tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: return tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  return tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: return tms ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: return tms ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: return tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: return tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: return tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: return tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  return tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: return tms ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: return tms ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: return tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: return tms ? TAP_SEL_DR : TAP_RTI;
            default:    return TAP_TLR;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_driver_if.sv
// Command/response bus between the host logic and the JTAG TAP driver.
interface jtag_tap_driver_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = $clog2(DATA_W)
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/tap_controller.sv
// TAP state tracker: follows the IEEE 1149.1 state machine from TMS so the
// driver always knows which state the target TAP is in.
module tap_controller
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output logic [3:0] STATE
);

    // Advance the shadow state once per TCK edge; TRST forces Test-Logic-Reset.
    always_ff @(posedge TCK) begin
        if (TRST) STATE <= TAP_TLR;
        else      STATE <= tap_next(STATE, TMS);
    end

endmodule

// File: rtl/jtag_tap_driver.sv
// JTAG initiator: turns RESET/IDLE/SHIFT_IR/SHIFT_DR commands into registered
// TMS/TDI walks, tracks the target TAP state and returns captured TDO bits.
// All next-cycle pin values are computed from the next FSM phase so TMS/TDI
// leave flops and the first walk bit appears the cycle after acceptance.
module jtag_tap_driver
    import jtag_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = $clog2(DATA_W)
)(
    input  logic              TCK,
    input  logic              TRST,
    jtag_tap_driver_if.slave  bus,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO,
    output logic [3:0]        STATE
);

    localparam int CNT_W = LEN_W + 1;

    drv_state_e        r_phase, w_phase_nxt;
    logic [CNT_W-1:0]  r_pos, w_pos_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_post, w_post_nxt;
    logic [1:0]        r_op, w_op_nxt;
    logic [LEN_W-1:0]  r_len, w_len_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic [DATA_W-1:0] r_cap, w_cap_nxt;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_tms, w_tms_nxt;
    logic              r_tdi, w_tdi_nxt;
    logic              r_ready, r_rsp_valid;
    logic [3:0]        w_state_nxt;
    logic              w_accept;
    logic              w_done_shift;
    logic [CNT_W-1:0]  w_len_ext;

    // TMS level at position pos of the lead-in walk from RTI.
    function automatic logic pre_tms(input logic [1:0] op, input logic [CNT_W-1:0] pos);
        case (op)
            OP_RESET:    return 1'b1;
            OP_IDLE:     return 1'b0;
            OP_SHIFT_IR: return pos < CNT_W'(2);
            default:     return pos == '0;
        endcase
    endfunction

    // Last position of the lead-in walk (IDLE dwells N cycles in RTI).
    function automatic logic [CNT_W-1:0] pre_last(input logic [1:0] op, input logic [CNT_W-1:0] len);
        case (op)
            OP_RESET:    return CNT_W'(4);
            OP_IDLE:     return len;
            OP_SHIFT_IR: return CNT_W'(3);
            default:     return CNT_W'(2);
        endcase
    endfunction

    tap_controller u_tap (
        .TCK   (TCK),
        .TRST  (TRST),
        .TMS   (r_tms),
        .STATE (STATE)
    );

    assign w_state_nxt  = tap_next(STATE, r_tms);
    assign w_accept     = bus.cmd_valid & r_ready;
    assign w_len_ext    = {1'b0, r_len};
    assign w_done_shift = (w_phase_nxt == D_DONE) && (r_op == OP_SHIFT_IR || r_op == OP_SHIFT_DR);

    // Next phase, counters and the TMS/TDI levels for the coming cycle.
    always_comb begin
        w_phase_nxt = r_phase;
        w_pos_nxt   = r_pos;
        w_cnt_nxt   = r_cnt;
        w_post_nxt  = r_post;
        w_op_nxt    = r_op;
        w_len_nxt   = r_len;
        w_data_nxt  = r_data;
        w_cap_nxt   = r_cap;
        // Idle level parks the TAP where it is (TLR holds on 1, RTI on 0).
        w_tms_nxt   = (w_state_nxt == TAP_TLR);
        w_tdi_nxt   = 1'b0;
        case (r_phase)
            D_READY, D_DONE: begin
                w_phase_nxt = D_READY;
                if (w_accept) begin
                    w_op_nxt   = bus.cmd_op;
                    w_len_nxt  = bus.cmd_len;
                    w_data_nxt = bus.cmd_data;
                    w_cap_nxt  = '0;
                    w_pos_nxt  = '0;
                    w_post_nxt = 1'b0;
                    if (w_state_nxt == TAP_TLR && bus.cmd_op != OP_RESET) begin
                        w_phase_nxt = D_PREFIX;
                        w_tms_nxt   = 1'b0;
                    end else begin
                        w_phase_nxt = D_WALK;
                        w_tms_nxt   = pre_tms(bus.cmd_op, '0);
                    end
                end
            end
            D_PREFIX: begin
                w_phase_nxt = D_WALK;
                w_pos_nxt   = '0;
                w_tms_nxt   = pre_tms(r_op, '0);
            end
            D_WALK: begin
                if (r_post) begin
                    // Exit tail: Exit1 -> Update (TMS=1 already shown), Update -> RTI.
                    if (r_pos == '0) begin
                        w_pos_nxt = CNT_W'(1);
                        w_tms_nxt = 1'b0;
                    end else begin
                        w_phase_nxt = D_DONE;
                    end
                end else if (r_pos == pre_last(r_op, w_len_ext)) begin
                    if (r_op == OP_SHIFT_IR || r_op == OP_SHIFT_DR) begin
                        w_phase_nxt = D_SHIFT;
                        w_cnt_nxt   = '0;
                        w_tms_nxt   = (w_len_ext == '0);
                        w_tdi_nxt   = r_data[0];
                    end else begin
                        w_phase_nxt = D_DONE;
                    end
                end else begin
                    w_pos_nxt = r_pos + CNT_W'(1);
                    w_tms_nxt = pre_tms(r_op, w_pos_nxt);
                end
            end
            D_SHIFT: begin
                w_cap_nxt[r_cnt[LEN_W-1:0]] = TDO;
                if (r_cnt == w_len_ext) begin
                    w_phase_nxt = D_WALK;
                    w_post_nxt  = 1'b1;
                    w_pos_nxt   = '0;
                    w_tms_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_tms_nxt = (w_cnt_nxt == w_len_ext);
                    w_tdi_nxt = r_data[w_cnt_nxt[LEN_W-1:0]];
                end
            end
            default: w_phase_nxt = D_READY;
        endcase
    end

    // Control state and pin registers; TRST aborts whatever is in flight.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            r_phase     <= D_READY;
            r_pos       <= '0;
            r_cnt       <= '0;
            r_post      <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_pos       <= w_pos_nxt;
            r_cnt       <= w_cnt_nxt;
            r_post      <= w_post_nxt;
            r_tms       <= w_tms_nxt;
            r_tdi       <= w_tdi_nxt;
            r_ready     <= (w_phase_nxt == D_READY) || (w_phase_nxt == D_DONE);
            r_rsp_valid <= w_done_shift;
            if (w_done_shift) r_rsp_data <= r_cap;
        end
    end

    // Command fields and the capture buffer need no reset.
    always_ff @(posedge TCK) begin
        r_op   <= w_op_nxt;
        r_len  <= w_len_nxt;
        r_data <= w_data_nxt;
        r_cap  <= w_cap_nxt;
    end

    assign TMS           = r_tms;
    assign TDI           = r_tdi;
    assign bus.cmd_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Directed bench for jtag_tap_driver with a small target TAP
// (8-bit DR reset to 0x3C, 4-bit IR reset to 0x5).
module tb_jtag_tap_driver;
    import jtag_pkg::*;

    logic       TCK;
    logic       TRST;
    logic       TMS;
    logic       TDI;
    logic       TDO;
    logic [3:0] STATE;

    jtag_tap_driver_if #(.DATA_W(32), .LEN_W(5)) bus ();

    jtag_tap_driver #(.DATA_W(32), .LEN_W(5)) dut (
        .TCK   (TCK),
        .TRST  (TRST),
        .bus   (bus.slave),
        .TMS   (TMS),
        .TDI   (TDI),
        .TDO   (TDO),
        .STATE (STATE)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    // Target TAP model
    logic [3:0] tgt_state;
    logic [7:0] tgt_dr;
    logic [3:0] tgt_ir;

    always_ff @(posedge TCK) begin
        if (TRST) begin
            tgt_state <= TAP_TLR;
            tgt_dr    <= 8'h3C;
            tgt_ir    <= 4'h5;
        end else begin
            tgt_state <= tap_next(tgt_state, TMS);
            if (tgt_state == TAP_SH_DR) tgt_dr <= {TDI, tgt_dr[7:1]};
            if (tgt_state == TAP_SH_IR) tgt_ir <= {TDI, tgt_ir[3:1]};
        end
    end

    assign TDO = (tgt_state == TAP_SH_DR) ? tgt_dr[0] :
                 (tgt_state == TAP_SH_IR) ? tgt_ir[0] : 1'b0;

    int n_shadow_mis = 0;
    always @(negedge TCK) begin
        if (tgt_state != STATE) n_shadow_mis++;
    end

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] tms_v, tdi_v, st_v;
    int          n_rsp, n_rdy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data);
        chk("ready_at_issue", 64'(bus.cmd_ready), 64'h1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        bus.cmd_data  = data;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Log TMS/TDI of each cycle and STATE after each edge, bit/nibble k = cycle k.
    task automatic record(input int cycles);
        tms_v = '0;
        tdi_v = '0;
        st_v  = '0;
        n_rsp = 0;
        n_rdy = 0;
        for (int k = 0; k < cycles; k++) begin
            tms_v = tms_v | (64'(TMS) << k);
            tdi_v = tdi_v | (64'(TDI) << k);
            tick();
            st_v  = st_v | (64'(STATE) << (4 * k));
            n_rsp += int'(bus.rsp_valid);
            if (k < cycles - 1) n_rdy += int'(bus.cmd_ready);
        end
    endtask

    task automatic shift_done(input string tag, input logic [31:0] exp_data);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'h1);
        chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(exp_data));
        chk({tag, "_ready"}, 64'(bus.cmd_ready), 64'h1);
        tick();
        chk({tag, "_rsp_drop"}, 64'(bus.rsp_valid), 64'h0);
    endtask

    int n_abort_rsp;

    initial begin
        TRST          = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_RESET;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;

        // Reset held for four cycles
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_tms", 64'(TMS), 64'h1);
            chk("rst_state", 64'(STATE), 64'h0);
            chk("rst_ready", 64'(bus.cmd_ready), 64'h0);
        end
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'h0);
        chk("rst_tdi", 64'(TDI), 64'h0);
        TRST = 1'b0;
        tick();
        chk("release_ready", 64'(bus.cmd_ready), 64'h1);
        chk("release_state", 64'(STATE), 64'h0);

        // IDLE N=3 from TLR: prefix plus three RTI cycles
        issue(OP_IDLE, 5'd2, 32'h0);
        record(4);
        chk("idle_tms", tms_v, 64'h0);
        chk("idle_state", st_v, 64'h1111);
        chk("idle_rsp", 64'(n_rsp), 64'h0);
        chk("idle_busy", 64'(n_rdy), 64'h0);
        chk("idle_ready", 64'(bus.cmd_ready), 64'h1);

        // SHIFT_DR N=8, 0xA5 in, target DR 0x3C out
        issue(OP_SHIFT_DR, 5'd7, 32'hA5);
        record(13);
        chk("dr_tms", tms_v, 64'h0C01);
        chk("dr_state", st_v, 64'h1854444444432);
        chk("dr_tdi", tdi_v, 64'h528);
        chk("dr_rsp_cnt", 64'(n_rsp), 64'h1);
        chk("dr_busy", 64'(n_rdy), 64'h0);
        chk("dr_target", 64'(tgt_dr), 64'hA5);
        shift_done("dr", 32'h0000003C);

        // SHIFT_IR N=4, 0x6 in, target IR 0x5 out
        issue(OP_SHIFT_IR, 5'd3, 32'h6);
        record(10);
        chk("ir_tms", tms_v, 64'h183);
        chk("ir_state", st_v, 64'h1FCBBBBA92);
        chk("ir_tdi", tdi_v, 64'h60);
        chk("ir_rsp_cnt", 64'(n_rsp), 64'h1);
        chk("ir_target", 64'(tgt_ir), 64'h6);
        shift_done("ir", 32'h00000005);

        // SHIFT_DR N=1: a single shift cycle that is also the exit cycle
        issue(OP_SHIFT_DR, 5'd0, 32'h1);
        record(6);
        chk("dr1_tms", tms_v, 64'h19);
        chk("dr1_state", st_v, 64'h185432);
        chk("dr1_tdi", tdi_v, 64'h8);
        chk("dr1_target", 64'(tgt_dr), 64'hD2);
        shift_done("dr1", 32'h00000001);

        // IDLE N=1 from RTI: no prefix, response data untouched
        issue(OP_IDLE, 5'd0, 32'h0);
        record(1);
        chk("idle1_tms", tms_v, 64'h0);
        chk("idle1_state", st_v, 64'h1);
        chk("idle1_rsp", 64'(n_rsp), 64'h0);
        chk("idle1_ready", 64'(bus.cmd_ready), 64'h1);
        chk("idle1_hold", 64'(bus.rsp_data), 64'h1);

        // RESET from RTI with a SHIFT_DR held valid behind it
        issue(OP_RESET, 5'd0, 32'h0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_SHIFT_DR;
        bus.cmd_len   = 5'd7;
        bus.cmd_data  = 32'h5A;
        record(5);
        chk("rst_cmd_tms", tms_v, 64'h1F);
        chk("rst_cmd_state", st_v, 64'h00092);
        chk("rst_cmd_busy", 64'(n_rdy), 64'h0);
        chk("rst_cmd_rsp", 64'(n_rsp), 64'h0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'h1);
        chk("rst_cmd_tms_park", 64'(TMS), 64'h1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("b2b_ready_drop", 64'(bus.cmd_ready), 64'h0);
        record(14);
        chk("b2b_tms", tms_v, 64'h1802);
        chk("b2b_state", st_v, 64'h18544444444321);
        chk("b2b_tdi", tdi_v, 64'h5A0);
        chk("b2b_target", 64'(tgt_dr), 64'h5A);
        shift_done("b2b", 32'h000000D2);

        // TRST during the third shift bit of a SHIFT_DR
        n_abort_rsp = 0;
        issue(OP_SHIFT_DR, 5'd7, 32'hFF);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_abort_rsp += int'(bus.rsp_valid);
        end
        chk("abort_in_shift", 64'(STATE), 64'(TAP_SH_DR));
        TRST = 1'b1;
        tick();
        chk("abort_state", 64'(STATE), 64'h0);
        chk("abort_tms", 64'(TMS), 64'h1);
        chk("abort_ready", 64'(bus.cmd_ready), 64'h0);
        n_abort_rsp += int'(bus.rsp_valid);
        tick();
        n_abort_rsp += int'(bus.rsp_valid);
        TRST = 1'b0;
        tick();
        n_abort_rsp += int'(bus.rsp_valid);
        chk("abort_ready_back", 64'(bus.cmd_ready), 64'h1);
        chk("abort_no_rsp", 64'(n_abort_rsp), 64'h0);
        chk("abort_rsp_data", 64'(bus.rsp_data), 64'h0);
        chk("abort_state_tlr", 64'(STATE), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_abort_rsp += int'(bus.rsp_valid);
        end
        chk("abort_idle_no_rsp", 64'(n_abort_rsp), 64'h0);

        chk("shadow_vs_target", 64'(n_shadow_mis), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
